// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and the logic that consumes its timing.
// The master side is the generator. The slave side is the pixel pipeline that drives the tick and restart inputs.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    // pix_en is a tick, not a valid/ready handshake. The generator advances one pixel on every
    // clk edge that sees pix_en=1, and it never applies backpressure. restart re-aligns the
    // generator on any edge and takes priority over pix_en. All outputs are registered.
    logic          pix_en;
    logic          restart;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
    logic          vblank;

    modport master (
        input  pix_en, restart,
        output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, vblank
    );

    modport slave (
        output pix_en, restart,
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, vblank
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator. It produces pixel/line counters, sync pulses, and blanking flags.
// All outputs are registered and are decoded from the next counter values, so sync and blanking never skew against pixel_x/pixel_y.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 12
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] H_SS    = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] H_SE    = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] V_SS    = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] V_SE    = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] x_nx, y_nx;
    logic          hsync_q, vsync_q, video_on_q, vblank_q, line_start_q, frame_start_q;

    always_comb begin
        x_nx = (x_q == H_LAST) ? '0 : x_q + CW'(1);
        y_nx = y_q;
        if (x_q == H_LAST) begin
            y_nx = (y_q == V_LAST) ? '0 : y_q + CW'(1);
        end
    end

    // Reset and restart both park the raster on the last pixel, so the next tick lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            vblank_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (bus.restart) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            vblank_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (bus.pix_en) begin
            x_q           <= x_nx;
            y_q           <= y_nx;
            hsync_q       <= ((x_nx >= H_SS) && (x_nx <= H_SE)) ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= ((y_nx >= V_SS) && (y_nx <= V_SE)) ? VSYNC_POL : ~VSYNC_POL;
            video_on_q    <= (x_nx < H_VIS) && (y_nx < V_VIS);
            vblank_q      <= (y_nx >= V_VIS);
            line_start_q  <= (x_nx == '0);
            frame_start_q <= (x_nx == '0) && (y_nx == '0);
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_on_q;
    assign bus.vblank      = vblank_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule
